// File: rtl/core_sequencer.sv
// core_sequencer: multicycle control FSM for the core.
// It steps FETCH -> DECODE -> EXEC -> (MEM) -> WRITE. It owns the instruction-
// and data-memory request/ready handshakes and latches the fetched instruction.
// It also drives the register-file and PC write strobes. It stops in HALT on
// ECALL or when a memory wait times out.
//
// Handshake rule: a request is raised combinationally from the current state.
// The access completes on the first posedge where both the request and its
// ready are high. A ready seen while no request is raised is ignored.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   run                allow new fetches (looked at only in FETCH)
//   imem_ready         instruction-fetch handshake complete; instr_in valid
//   instr_in           instruction word from instruction memory
//   mem_read/mem_write decode outputs; these choose whether MEM is visited
//   reg_write          decode output; gates rf_we in WRITE
//   dmem_ready         data access complete
//   state              current FSM state (0..5), exposed for debug
//   instr_raw          latched instruction
//   imem_req/dmem_req  memory requests (combinational)
//   rf_we/pc_we        write strobes (combinational)
//   halt, err          halted; err is set when a timeout caused the halt
//   instr_count        retired-instruction counter
module core_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [31:0]      instr_in,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             dmem_ready,
  output logic [2:0]       state,
  output logic [31:0]      instr_raw,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam int          WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic               halt_q, halt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W:0]    wait_inc;
  logic               timeout;

  // The counter is one bit wider so the compare cannot overflow.
  // A waiting cycle that would bring the counter to MEM_TIMEOUT halts.
  assign wait_inc = {1'b0, wait_q} + 1'b1;
  assign timeout  = (wait_inc >= (WAIT_W + 1)'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    halt_d   = halt_q;
    err_d    = err_q;
    count_d  = count_q;
    wait_d   = wait_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = run;
        if (!run) begin
          wait_d = '0;
        end else if (imem_ready) begin
          instr_d = instr_in;
          state_d = S_DECODE;
          wait_d  = '0;
        end else if (timeout) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // A read and a write both set is still one data access.
        if (mem_read || mem_write) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = S_WRITE;
          wait_d  = '0;
        end else if (timeout) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end
      S_WRITE: begin
        if (instr_q == ECALL) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          rf_we   = reg_write;
          pc_we   = 1'b1;
          count_d = count_q + 1'b1;
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
    endcase
    // While reset is held, no request or strobe may leak out.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_raw   = instr_q;
  assign halt        = halt_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] LW    = 32'h0000_2083;
  localparam logic [31:0] SW    = 32'h0010_2023;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready, mem_read, mem_write, reg_write, dmem_ready;
  logic [31:0] instr_in;
  logic [2:0]  state;
  logic [31:0] instr_raw;
  logic        imem_req, dmem_req, rf_we, pc_we, halt, err;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = '0;

  core_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .instr_in(instr_in),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .dmem_ready(dmem_ready), .state(state), .instr_raw(instr_raw),
    .imem_req(imem_req), .dmem_req(dmem_req), .rf_we(rf_we), .pc_we(pc_we),
    .halt(halt), .err(err), .instr_count(instr_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; the bench then samples 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_count = '0;
  endtask

  // Fetch with imem_ready held low for 'delay' cycles. Leaves the FSM in DECODE.
  task automatic fetch(input logic [31:0] instr, input int delay);
    run = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      #1;
      check("fetch_wait_state", 32'(state), 32'd0);
      check("fetch_wait_req", 32'(imem_req), 32'd1);
      tick();
    end
    imem_ready = 1'b1;
    instr_in = instr;
    #1;
    check("fetch_req", 32'(imem_req), 32'd1);
    tick();
    imem_ready = 1'b0;
    run = 1'b0;
    instr_in = 32'hdead_beef;
    check("decode_state", 32'(state), 32'd1);
    check("instr_raw", instr_raw, instr);
  endtask

  // From DECODE: run EXEC, optional MEM (dmem_ready after 'dly' cycles), WRITE.
  task automatic finish_instr(input logic rd, input logic wr, input logic rw,
                              input int dly, input logic is_ecall);
    mem_read = rd;
    mem_write = wr;
    reg_write = rw;
    tick();
    check("exec_state", 32'(state), 32'd2);
    check("exec_pc_we", 32'(pc_we), 32'd0);
    if (rd || wr) begin
      tick();
      for (int i = 0; i < dly; i++) begin
        check("mem_wait_state", 32'(state), 32'd3);
        check("mem_wait_req", 32'(dmem_req), 32'd1);
        tick();
      end
      dmem_ready = 1'b1;
      #1;
      check("mem_state", 32'(state), 32'd3);
      check("mem_req", 32'(dmem_req), 32'd1);
      tick();
      dmem_ready = 1'b0;
      #1;
    end else begin
      tick();
    end
    check("write_state", 32'(state), 32'd4);
    check("write_rf_we", 32'(rf_we), 32'(rw && !is_ecall));
    check("write_pc_we", 32'(pc_we), 32'(!is_ecall));
    check("write_dmem_req", 32'(dmem_req), 32'd0);
    if (!is_ecall) exp_count = exp_count + 1;
    tick();
    check("after_write_state", 32'(state), is_ecall ? 32'd5 : 32'd0);
    check("instr_count", instr_count, exp_count);
    check("halt", 32'(halt), 32'(is_ecall));
    mem_read = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; imem_ready = 1'b1; instr_in = ADDI;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; dmem_ready = 1'b1;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_instr_raw", instr_raw, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    rst = 1'b0;
    tick();

    // addi, imem_ready 2 cycles late
    fetch(ADDI, 2);
    // a stray dmem_ready outside MEM must be ignored
    dmem_ready = 1'b1;
    finish_instr(1'b0, 1'b0, 1'b1, 0, 1'b0);
    dmem_ready = 1'b0;

    // run=0 in FETCH: no request and no timeout
    for (int i = 0; i < 8; i++) begin
      check("idle_req", 32'(imem_req), 32'd0);
      check("idle_state", 32'(state), 32'd0);
      tick();
    end

    // lw, dmem_ready 3 cycles into MEM: 4 MEM cycles, one below the timeout
    fetch(LW, 0);
    finish_instr(1'b1, 1'b0, 1'b1, 3, 1'b0);
    // sw, dmem_ready immediate
    fetch(SW, 1);
    finish_instr(1'b0, 1'b1, 1'b0, 0, 1'b0);
    // read and write both set: a single access
    fetch(LW, 0);
    finish_instr(1'b1, 1'b1, 1'b1, 0, 1'b0);

    // ECALL halts; the count is unchanged
    fetch(ECALL, 0);
    finish_instr(1'b0, 1'b0, 1'b0, 0, 1'b1);
    check("ecall_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      tick();
      check("halt_hold_state", 32'(state), 32'd5);
      check("halt_hold_req", 32'(imem_req | dmem_req | rf_we | pc_we), 32'd0);
    end
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset();
    check("post_halt_state", 32'(state), 32'd0);
    check("post_halt_halt", 32'(halt), 32'd0);
    check("post_halt_count", instr_count, 32'd0);

    // fetch timeout: 4 FETCH cycles with ready low, then HALT with err set
    run = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_fetch_state", 32'(state), 32'd0);
      tick();
    end
    check("to_state", 32'(state), 32'd5);
    check("to_err", 32'(err), 32'd1);
    check("to_halt", 32'(halt), 32'd1);
    check("to_req", 32'(imem_req), 32'd0);
    run = 1'b0;
    do_reset();
    check("to_rst_err", 32'(err), 32'd0);

    // data-memory timeout: 4 MEM cycles with ready low
    fetch(LW, 0);
    mem_read = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("dto_mem_state", 32'(state), 32'd3);
      tick();
    end
    check("dto_state", 32'(state), 32'd5);
    check("dto_err", 32'(err), 32'd1);
    check("dto_req", 32'(dmem_req), 32'd0);
    mem_read = 1'b0;
    do_reset();

    // reset in the middle of a MEM access
    fetch(ADDI, 0);
    finish_instr(1'b0, 1'b0, 1'b1, 0, 1'b0);
    fetch(LW, 0);
    mem_read = 1'b1;
    tick();
    tick();
    check("mid_mem_state", 32'(state), 32'd3);
    check("mid_mem_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    tick();
    rst = 1'b0;
    mem_read = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_rst_count", instr_count, 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
